alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Two-requester arbiter that time-shares one `ALU32Bit` instance. Each requester has its own request and response channel with valid/ready handshakes. The block registers the winning requester's operands and runs one ALU evaluation. It holds the result until that requester accepts it. Round-robin priority prevents starvation. It sits between the register-read stage of two issuing units and the single shared ALU.

## Interface
- `DATA_WIDTH`, 32, operand/result width; must stay 32 to match `ALU32Bit`.
- `OPCODE_WIDTH`, 3, ALU opcode width; must stay 3.

- `clk_i`  input  1  single clock, all state on rising edge.
- `rst_ni`  input  1  reset, asynchronous, active-low.
- `req0_valid_i` / `req1_valid_i`  input  1  requester k has an operation pending.
- `req0_ready_o` / `req1_ready_o`  output  1  operation of requester k accepted this cycle.
- `req0_source_i` / `req1_source_i`  input  32  source operand.
- `req0_target_i` / `req1_target_i`  input  32  target operand (shift amount = target[5:0] for opcode 110).
- `req0_opcode_i` / `req1_opcode_i`  input  3  ALU opcode (000 add, 001 sub, 010 and, 011 or, 100 xor, 101 not source, 110 shift-left, 111 zero).
- `rsp0_valid_o` / `rsp1_valid_o`  output  1  result for requester k available.
- `rsp0_ready_i` / `rsp1_ready_i`  input  1  requester k consumes result.
- `rsp_result_o`  output  32  shared result bus, meaningful only while a `rspk_valid_o` is high.
- `rsp_overflow_o`  output  1  ALU overflow for that result, passed through unmodified.
- `busy_o`  output  1  high in EXEC and RESP.
- `grant_id_o`  output  1  index of the requester currently owning the ALU (valid while `busy_o`).

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE
  - If neither valid is high, stay in IDLE.
  - If exactly one requester is valid, grant it.
  - If both are valid, grant the requester named by the priority pointer `prio`.
  - `reqk_ready_o` is high combinationally in IDLE for the granted k only.
  - On grant: capture source, target and opcode into operand registers, set `grant_id`, go to EXEC.
- EXEC
  - The ALU is driven only from the operand registers.
  - Capture the ALU result and overflow into the response registers, then go to RESP.
- RESP
  - `rsp{grant_id}_valid_o` is high; the other response valid stays low.
  - When `rsp{grant_id}_ready_i` is high: set `prio` to the opposite of `grant_id`, then go to IDLE.
  - While ready is low: stay in RESP with result, overflow and grant_id stable.
- `prio` resets to 0. It changes only on response completion, never on grant.
- Both `reqk_ready_o` are low in EXEC and RESP. Any requester valid during those states waits.
- The operand registers are loaded only on the accept cycle. Input changes after acceptance do not affect the result.
- Requesters keep valid and operands stable until ready. The arbiter does not check this.
- The arbiter does no arithmetic. Width, overflow and shift semantics are entirely those of `ALU32Bit`. Overflow is not masked for logical opcodes.

## Timing
- Reset values: all `reqk_ready_o` 0, all `rspk_valid_o` 0, `rsp_result_o` 0, `rsp_overflow_o` 0, `busy_o` 0, `grant_id_o` 0, `prio` 0. Operand registers are cleared to 0.
- Accept at cycle N (IDLE, valid&&ready) gives:
  - EXEC at N+1;
  - `rspk_valid_o` high from N+2;
  - earliest response handshake at N+2.
- Response handshake at cycle M puts the FSM in IDLE at M+1. The next accept can happen at M+1, so peak throughput is one operation per 3 cycles.
- A response valid never asserts in the same cycle as its accept.
- Reset asserted in any state clears all state immediately (asynchronous). An in-flight operation is discarded with no response. Operation resumes in IDLE on the first clock edge after `rst_ni` rises.
- If a requester drops valid in IDLE before being granted, nothing happens. A grant requires valid in that same cycle.

## Test plan
- Single add with overflow: req0, source -1073741829, target -1073741829, opcode 000, accepted at cycle N -> `rsp0_valid_o` at N+2, result 2147483638, overflow 1, `rsp1_valid_o` stays 0.
- Simultaneous requests after reset: req0 sub -1073741829 - 1073741829; req1 xor 0x0F0F0F0F ^ 0xFFFF0000. Expected sequence:
  - req0 granted first: result 2147483638, overflow 1;
  - then req1: result 0xF0F00F0F.
  - `grant_id_o` reads 0 then 1.
- Round-robin: both valid continuously with rsp ready always high for 4 operations -> grant order 0,1,0,1, accept cycles exactly 3 apart.
- Backpressure: req1 shift-left source 1, target 0x00000045 -> result 32. With `rsp1_ready_i` low for 5 cycles, result, overflow and valid stay stable and `req0_ready_o` stays 0. req0 is accepted the cycle after the rsp1 handshake.
- Reset mid-operation: assert `rst_ni` low during EXEC of a req1 operation. Expected:
  - all outputs at reset values immediately, and no response ever appears for that operation;
  - after release, with both valid, req0 wins (`prio` = 0).
- Opcodes 101 and 111: not of 0x00000000 -> 0xFFFFFFFF; opcode 111 with any operands -> result 0. Both are delivered with the standard 2-cycle latency.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: two requesters time-share a single ALU32Bit instance.
// The winner's operands are registered on accept, evaluated once, and the
// result is held on a shared response bus until the owning requester takes it.
// A round-robin pointer, updated only on response completion, breaks ties.

// ALU32Bit: purely combinational 32-bit ALU. Overflow is signed overflow for
// add/sub and low for every other opcode; shift amount is target[5:0], so
// shifts of 32 or more produce zero.
module ALU32Bit (
  input  logic [2:0]  opcode_i,
  input  logic [31:0] source_i,
  input  logic [31:0] target_i,
  output logic [31:0] result_o,
  output logic        overflow_o
);

  logic [31:0] sumVal;
  logic [31:0] diffVal;

  assign sumVal  = source_i + target_i;
  assign diffVal = source_i - target_i;

  // Decode the opcode into a result and the signed-overflow flag.
  always_comb begin
    result_o   = '0;
    overflow_o = 1'b0;
    case (opcode_i)
      3'b000: begin
        result_o   = sumVal;
        overflow_o = (source_i[31] == target_i[31]) && (sumVal[31] != source_i[31]);
      end
      3'b001: begin
        result_o   = diffVal;
        overflow_o = (source_i[31] != target_i[31]) && (diffVal[31] != source_i[31]);
      end
      3'b010: result_o = source_i & target_i;
      3'b011: result_o = source_i | target_i;
      3'b100: result_o = source_i ^ target_i;
      3'b101: result_o = ~source_i;
      3'b110: result_o = source_i << target_i[5:0];
      3'b111: result_o = '0;
      default: result_o = '0;
    endcase
  end

endmodule

module alu_share_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int OPCODE_WIDTH = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req0_valid_i,
  output logic                    req0_ready_o,
  input  logic [DATA_WIDTH-1:0]   req0_source_i,
  input  logic [DATA_WIDTH-1:0]   req0_target_i,
  input  logic [OPCODE_WIDTH-1:0] req0_opcode_i,
  input  logic                    req1_valid_i,
  output logic                    req1_ready_o,
  input  logic [DATA_WIDTH-1:0]   req1_source_i,
  input  logic [DATA_WIDTH-1:0]   req1_target_i,
  input  logic [OPCODE_WIDTH-1:0] req1_opcode_i,
  output logic                    rsp0_valid_o,
  input  logic                    rsp0_ready_i,
  output logic                    rsp1_valid_o,
  input  logic                    rsp1_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_result_o,
  output logic                    rsp_overflow_o,
  output logic                    busy_o,
  output logic                    grant_id_o
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } state_e;

  state_e                  state_q;
  logic                    prio_q;
  logic                    grantId_q;
  logic                    busy_q;
  logic                    rsp0Valid_q;
  logic                    rsp1Valid_q;
  logic [DATA_WIDTH-1:0]   result_q;
  logic                    overflow_q;
  logic [DATA_WIDTH-1:0]   source_q;
  logic [DATA_WIDTH-1:0]   target_q;
  logic [OPCODE_WIDTH-1:0] opcode_q;

  logic                    grantSel_d;
  logic [DATA_WIDTH-1:0]   source_d;
  logic [DATA_WIDTH-1:0]   target_d;
  logic [OPCODE_WIDTH-1:0] opcode_d;
  logic                    anyValid;
  logic                    acceptEn;
  logic                    rspReady;
  logic [DATA_WIDTH-1:0]   aluResult;
  logic                    aluOverflow;

  assign anyValid = req0_valid_i | req1_valid_i;
  assign acceptEn = rst_ni && (state_q == StIdle) && anyValid;

  // Choose the winner: a lone requester wins outright, otherwise the pointer decides.
  always_comb begin
    grantSel_d = prio_q;
    if (req0_valid_i && !req1_valid_i) begin
      grantSel_d = 1'b0;
    end else if (!req0_valid_i && req1_valid_i) begin
      grantSel_d = 1'b1;
    end
  end

  // Steer the winner's operands toward the operand registers.
  always_comb begin
    source_d = req0_source_i;
    target_d = req0_target_i;
    opcode_d = req0_opcode_i;
    if (grantSel_d) begin
      source_d = req1_source_i;
      target_d = req1_target_i;
      opcode_d = req1_opcode_i;
    end
  end

  assign req0_ready_o = acceptEn && !grantSel_d;
  assign req1_ready_o = acceptEn &&  grantSel_d;

  assign rspReady = grantId_q ? rsp1_ready_i : rsp0_ready_i;

  ALU32Bit uAlu (
    .opcode_i   (opcode_q),
    .source_i   (source_q),
    .target_i   (target_q),
    .result_o   (aluResult),
    .overflow_o (aluOverflow)
  );

  // Arbitration FSM: accept in IDLE, evaluate in EXEC, hold the response in RESP.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      prio_q      <= 1'b0;
      grantId_q   <= 1'b0;
      busy_q      <= 1'b0;
      rsp0Valid_q <= 1'b0;
      rsp1Valid_q <= 1'b0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      source_q    <= '0;
      target_q    <= '0;
      opcode_q    <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (anyValid) begin
            source_q  <= source_d;
            target_q  <= target_d;
            opcode_q  <= opcode_d;
            grantId_q <= grantSel_d;
            busy_q    <= 1'b1;
            state_q   <= StExec;
          end
        end
        StExec: begin
          result_q    <= aluResult;
          overflow_q  <= aluOverflow;
          rsp0Valid_q <= !grantId_q;
          rsp1Valid_q <= grantId_q;
          state_q     <= StResp;
        end
        StResp: begin
          if (rspReady) begin
            rsp0Valid_q <= 1'b0;
            rsp1Valid_q <= 1'b0;
            busy_q      <= 1'b0;
            prio_q      <= !grantId_q;
            state_q     <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign rsp0_valid_o   = rsp0Valid_q;
  assign rsp1_valid_o   = rsp1Valid_q;
  assign rsp_result_o   = result_q;
  assign rsp_overflow_o = overflow_q;
  assign busy_o         = busy_q;
  assign grant_id_o     = grantId_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed checks of the shared-ALU arbiter.
// Inputs change just after each falling edge; outputs are sampled 1 ns later.
module tb_alu_share_arbiter;

  localparam logic [2:0] OpAdd  = 3'b000;
  localparam logic [2:0] OpSub  = 3'b001;
  localparam logic [2:0] OpAnd  = 3'b010;
  localparam logic [2:0] OpXor  = 3'b100;
  localparam logic [2:0] OpNot  = 3'b101;
  localparam logic [2:0] OpShl  = 3'b110;
  localparam logic [2:0] OpZero = 3'b111;

  logic        clock;
  logic        rstN;
  logic        req0Valid, req1Valid;
  logic        req0Ready, req1Ready;
  logic [31:0] req0Source, req0Target, req1Source, req1Target;
  logic [2:0]  req0Opcode, req1Opcode;
  logic        rsp0Valid, rsp1Valid;
  logic        rsp0Ready, rsp1Ready;
  logic [31:0] rspResult;
  logic        rspOverflow;
  logic        busy;
  logic        grantId;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  alu_share_arbiter dut (
    .clk_i          (clock),
    .rst_ni         (rstN),
    .req0_valid_i   (req0Valid),
    .req0_ready_o   (req0Ready),
    .req0_source_i  (req0Source),
    .req0_target_i  (req0Target),
    .req0_opcode_i  (req0Opcode),
    .req1_valid_i   (req1Valid),
    .req1_ready_o   (req1Ready),
    .req1_source_i  (req1Source),
    .req1_target_i  (req1Target),
    .req1_opcode_i  (req1Opcode),
    .rsp0_valid_o   (rsp0Valid),
    .rsp0_ready_i   (rsp0Ready),
    .rsp1_valid_o   (rsp1Valid),
    .rsp1_ready_i   (rsp1Ready),
    .rsp_result_o   (rspResult),
    .rsp_overflow_o (rspOverflow),
    .busy_o         (busy),
    .grant_id_o     (grantId)
  );

  // Free-running 10 ns clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic v1, input logic r0, input logic r1);
    @(negedge clock);
    req0Valid = v0;
    req1Valid = v1;
    rsp0Ready = r0;
    rsp1Ready = r1;
    #1;
  endtask

  task automatic setReq0(input logic [2:0] op, input logic [31:0] src, input logic [31:0] tgt);
    req0Opcode = op;
    req0Source = src;
    req0Target = tgt;
  endtask

  task automatic setReq1(input logic [2:0] op, input logic [31:0] src, input logic [31:0] tgt);
    req1Opcode = op;
    req1Source = src;
    req1Target = tgt;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ready0"}, 32'(req0Ready), 32'd0);
    checkOutput({tag, "_ready1"}, 32'(req1Ready), 32'd0);
    checkOutput({tag, "_rsp0v"}, 32'(rsp0Valid), 32'd0);
    checkOutput({tag, "_rsp1v"}, 32'(rsp1Valid), 32'd0);
    checkOutput({tag, "_result"}, rspResult, 32'd0);
    checkOutput({tag, "_ovf"}, 32'(rspOverflow), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_grant"}, 32'(grantId), 32'd0);
  endtask

  // Directed sequence: reset, single op, tie, round-robin, opcodes, backpressure, mid-op reset.
  initial begin
    rstN = 1'b0;
    req0Valid = 1'b0;
    req1Valid = 1'b0;
    rsp0Ready = 1'b0;
    rsp1Ready = 1'b0;
    setReq0(OpAdd, 32'd0, 32'd0);
    setReq1(OpAdd, 32'd0, 32'd0);
    #2;
    checkResetValues("reset");
    @(negedge clock);
    rstN = 1'b1;

    // Single add with overflow from req0
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    setReq0(OpAdd, 32'hBFFF_FFFB, 32'hBFFF_FFFB);
    checkOutput("t1_ready0", 32'(req0Ready), 32'd1);
    checkOutput("t1_ready1", 32'(req1Ready), 32'd0);
    checkOutput("t1_rsp0v_accept", 32'(rsp0Valid), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("t1_busy_exec", 32'(busy), 32'd1);
    checkOutput("t1_grant", 32'(grantId), 32'd0);
    checkOutput("t1_rsp0v_exec", 32'(rsp0Valid), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("t1_rsp0v", 32'(rsp0Valid), 32'd1);
    checkOutput("t1_rsp1v", 32'(rsp1Valid), 32'd0);
    checkOutput("t1_result", rspResult, 32'd2147483638);
    checkOutput("t1_ovf", 32'(rspOverflow), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("t1_rsp0v_done", 32'(rsp0Valid), 32'd0);
    checkOutput("t1_busy_done", 32'(busy), 32'd0);

    // Fresh reset so the priority pointer starts at 0
    @(negedge clock);
    rstN = 1'b0;
    @(negedge clock);
    rstN = 1'b1;

    // Simultaneous requests: req0 sub first, then req1 xor
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    setReq0(OpSub, 32'hBFFF_FFFB, 32'h4000_0005);
    setReq1(OpXor, 32'h0F0F_0F0F, 32'hFFFF_0000);
    checkOutput("t2_ready0", 32'(req0Ready), 32'd1);
    checkOutput("t2_ready1", 32'(req1Ready), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("t2_grant0", 32'(grantId), 32'd0);
    checkOutput("t2_ready1_exec", 32'(req1Ready), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("t2_rsp0v", 32'(rsp0Valid), 32'd1);
    checkOutput("t2_rsp1v_wait", 32'(rsp1Valid), 32'd0);
    checkOutput("t2_result0", rspResult, 32'd2147483638);
    checkOutput("t2_ovf0", 32'(rspOverflow), 32'd1);
    checkOutput("t2_ready1_resp", 32'(req1Ready), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("t2_ready1", 32'(req1Ready), 32'd1);
    checkOutput("t2_rsp0v_done", 32'(rsp0Valid), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("t2_grant1", 32'(grantId), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("t2_rsp1v", 32'(rsp1Valid), 32'd1);
    checkOutput("t2_rsp0v", 32'(rsp0Valid), 32'd0);
    checkOutput("t2_result1", rspResult, 32'hF0F0_0F0F);
    checkOutput("t2_ovf1", 32'(rspOverflow), 32'd0);

    // Round-robin: both valid, responses always ready, four operations
    setReq0(OpAdd, 32'd1, 32'd2);
    setReq1(OpAnd, 32'hFF00_FF00, 32'h0FF0_0FF0);
    for (int k = 0; k < 12; k++) begin
      int phase;
      int owner;
      phase = k % 3;
      owner = (k / 3) % 2;
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
      if (phase == 0) begin
        checkOutput($sformatf("rr%0d_ready0", k), 32'(req0Ready), 32'(owner == 0));
        checkOutput($sformatf("rr%0d_ready1", k), 32'(req1Ready), 32'(owner == 1));
      end else if (phase == 1) begin
        checkOutput($sformatf("rr%0d_ready0", k), 32'(req0Ready), 32'd0);
        checkOutput($sformatf("rr%0d_ready1", k), 32'(req1Ready), 32'd0);
        checkOutput($sformatf("rr%0d_grant", k), 32'(grantId), 32'(owner));
      end else begin
        checkOutput($sformatf("rr%0d_rsp0v", k), 32'(rsp0Valid), 32'(owner == 0));
        checkOutput($sformatf("rr%0d_rsp1v", k), 32'(rsp1Valid), 32'(owner == 1));
        checkOutput($sformatf("rr%0d_result", k), rspResult, (owner == 0) ? 32'd3 : 32'h0F00_0F00);
      end
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("rr_busy_done", 32'(busy), 32'd0);

    // Opcode 111 always yields zero
    setReq0(OpZero, 32'h1234_5678, 32'h9ABC_DEF0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("zero_ready0", 32'(req0Ready), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("zero_rsp0v_exec", 32'(rsp0Valid), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("zero_rsp0v", 32'(rsp0Valid), 32'd1);
    checkOutput("zero_result", rspResult, 32'd0);
    checkOutput("zero_ovf", 32'(rspOverflow), 32'd0);

    // Backpressure on req1 shift-left, req0 waiting behind it
    setReq1(OpShl, 32'd1, 32'h0000_0045);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("bp_ready1", 32'(req1Ready), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    setReq0(OpNot, 32'd0, 32'd0);
    checkOutput("bp_ready0_exec", 32'(req0Ready), 32'd0);
    checkOutput("bp_busy_exec", 32'(busy), 32'd1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("bp%0d_rsp1v", i), 32'(rsp1Valid), 32'd1);
      checkOutput($sformatf("bp%0d_result", i), rspResult, 32'd32);
      checkOutput($sformatf("bp%0d_ovf", i), 32'(rspOverflow), 32'd0);
      checkOutput($sformatf("bp%0d_grant", i), 32'(grantId), 32'd1);
      checkOutput($sformatf("bp%0d_ready0", i), 32'(req0Ready), 32'd0);
      checkOutput($sformatf("bp%0d_rsp0v", i), 32'(rsp0Valid), 32'd0);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("bp_rsp1v_hs", 32'(rsp1Valid), 32'd1);
    checkOutput("bp_ready0_hs", 32'(req0Ready), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("bp_ready0_after", 32'(req0Ready), 32'd1);
    checkOutput("bp_rsp1v_after", 32'(rsp1Valid), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("not_grant", 32'(grantId), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("not_rsp0v", 32'(rsp0Valid), 32'd1);
    checkOutput("not_result", rspResult, 32'hFFFF_FFFF);

    // Reset during EXEC of a req1 operation
    setReq1(OpAdd, 32'd5, 32'd6);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("mr_ready1", 32'(req1Ready), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("mr_busy_exec", 32'(busy), 32'd1);
    checkOutput("mr_grant_exec", 32'(grantId), 32'd1);
    rstN = 1'b0;
    #1;
    checkResetValues("mr_reset");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("mr_rsp1v_inreset", 32'(rsp1Valid), 32'd0);
    rstN = 1'b1;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      checkOutput($sformatf("mr%0d_rsp1v", i), 32'(rsp1Valid), 32'd0);
      checkOutput($sformatf("mr%0d_busy", i), 32'(busy), 32'd0);
    end
    setReq0(OpAdd, 32'd7, 32'd8);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("mr_ready0_prio", 32'(req0Ready), 32'd1);
    checkOutput("mr_ready1_prio", 32'(req1Ready), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("mr_grant0", 32'(grantId), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("mr_rsp0v", 32'(rsp0Valid), 32'd1);
    checkOutput("mr_result0", rspResult, 32'd15);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("mr_ready1", 32'(req1Ready), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("mr_rsp1v", 32'(rsp1Valid), 32'd1);
    checkOutput("mr_result1", rspResult, 32'd11);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
